// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetches over a read/valid memory port,
// buffered with their PCs in a DEPTH-entry FIFO. Define FETCH_QUEUE_BYPASS_EN to forward into an empty queue.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     halt_in,
    input  logic                     flush_in,
    input  logic [31:0]              flush_addr_in,
    output logic [31:0]              mem_addr_out,
    output logic                     mem_read_out,
    input  logic                     mem_valid_in,
    input  logic [31:0]              mem_data_in,
    output logic                     ins_valid_out,
    output logic [31:0]              ins_data_out,
    output logic [31:0]              ins_pc_out,
    input  logic                     ins_ready_in,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     mem_addr_q, mem_addr_d;

    logic [31:0]     data_mem_q [DEPTH];
    logic [31:0]     pc_mem_q   [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic [31:0]     head_data_q, head_data_d;
    logic [31:0]     head_pc_q, head_pc_d;

    logic            resp_ok;
    logic            byp_active;
    logic            byp_take;
    logic            push;
    logic            pop;
    logic [CW-1:0]   cnt_after_pop;

    // A response only counts when it completes a live (non-discarded) request and no flush cancels it.
    assign resp_ok = (state_q == ST_WAIT) && mem_valid_in && !flush_in;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp_active = (count_q == '0) && resp_ok;
`else
    assign byp_active = 1'b0;
`endif

    assign byp_take = byp_active && ins_ready_in;
    assign push     = resp_ok && !byp_take;
    assign pop      = valid_q && ins_ready_in && !flush_in;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (!halt_in && !flush_in && (count_q < CW'(DEPTH))) begin
                    state_d    = ST_WAIT;
                    mem_addr_d = fetch_pc_q;
                end
            end
            ST_WAIT: begin
                if (mem_valid_in) begin
                    state_d = ST_IDLE;
                    if (!flush_in) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (flush_in) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mem_valid_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush_in) begin
            fetch_pc_d = flush_addr_in;
        end
    end

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        valid_d       = valid_q;
        head_data_d   = head_data_q;
        head_pc_d     = head_pc_q;
        cnt_after_pop = count_q - CW'(pop);
        if (flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            valid_d = (count_d != '0);
            // The head register shows the next entry; an empty queue keeps the last one shown.
            if (count_d != '0) begin
                if (cnt_after_pop == '0) begin
                    head_data_d = mem_data_in;
                    head_pc_d   = fetch_pc_q;
                end else begin
                    head_data_d = data_mem_q[rd_ptr_d];
                    head_pc_d   = pc_mem_q[rd_ptr_d];
                end
            end else if (byp_take) begin
                head_data_d = mem_data_in;
                head_pc_d   = fetch_pc_q;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            mem_addr_q  <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            head_data_q <= '0;
            head_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            mem_addr_q  <= mem_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            head_data_q <= head_data_d;
            head_pc_q   <= head_pc_d;
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clock_in) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= mem_data_in;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign mem_read_out = (state_q != ST_IDLE);
    assign mem_addr_out = mem_addr_q;
    assign count_out    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign ins_valid_out = byp_active ? 1'b1        : valid_q;
    assign ins_data_out  = byp_active ? mem_data_in : head_data_q;
    assign ins_pc_out    = byp_active ? fetch_pc_q  : head_pc_q;
`else
    assign ins_valid_out = valid_q;
    assign ins_data_out  = head_data_q;
    assign ins_pc_out    = head_pc_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: randomized memory latency and decode back-pressure against a
// stream-level model (expected entries queue, next request address, outstanding/discard flag).
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk;
  logic          reset_in, halt_in, flush_in;
  logic [31:0]   flush_addr_in;
  logic [31:0]   mem_addr_out;
  logic          mem_read_out;
  logic          mem_valid_in;
  logic [31:0]   mem_data_in;
  logic          ins_valid_out;
  logic [31:0]   ins_data_out, ins_pc_out;
  logic          ins_ready_in;
  logic [CW-1:0] count_out;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock_in      (clk),
    .reset_in      (reset_in),
    .halt_in       (halt_in),
    .flush_in      (flush_in),
    .flush_addr_in (flush_addr_in),
    .mem_addr_out  (mem_addr_out),
    .mem_read_out  (mem_read_out),
    .mem_valid_in  (mem_valid_in),
    .mem_data_in   (mem_data_in),
    .ins_valid_out (ins_valid_out),
    .ins_data_out  (ins_data_out),
    .ins_pc_out    (ins_pc_out),
    .ins_ready_in  (ins_ready_in),
    .count_out     (count_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and model state
  logic [63:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          delivered = 0;
  logic        model_ok = 1'b0;
  logic        discard = 1'b0;
  logic        exp_read = 1'b0;
  logic [31:0] exp_req = RESET_PC;
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] last_pc = '0;
  logic [31:0] last_data = '0;

  logic        s_rst, s_halt, s_flush, s_read, s_valid, s_ready;
  logic [31:0] s_faddr, s_data;

  // memory responder controls
  logic mem_en = 1'b0;
  logic rand_lat = 1'b0;
  int   lat = 0;
  int   wait_cnt = 0;

  // One clock: check outputs at negedge, capture inputs, advance model after the edge, run memory.
  task automatic tick();
    logic        ev, resp, byp, nxt;
    logic [31:0] epc, edata;
    @(negedge clk);
    if (model_ok) begin
      checks++;
      if (count_out !== CW'(exp_q.size())) begin
        errors++; $display("FAIL count: got %0d expected %0d", count_out, exp_q.size());
      end
      checks++;
      if (mem_read_out !== exp_read) begin
        errors++; $display("FAIL mem_read: got %0b expected %0b", mem_read_out, exp_read);
      end
      if (exp_read) begin
        checks++;
        if (mem_addr_out !== exp_addr) begin
          errors++; $display("FAIL mem_addr: got %h expected %h", mem_addr_out, exp_addr);
        end
      end
      ev = (exp_q.size() != 0);
      epc = last_pc;
      edata = last_data;
      if (ev) begin
        {epc, edata} = exp_q[0];
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      else if (exp_read && !discard && mem_valid_in && !flush_in) begin
        ev = 1'b1; epc = exp_addr; edata = mem_data_in;
      end
`endif
      last_pc = epc;
      last_data = edata;
      checks++;
      if (ins_valid_out !== ev) begin
        errors++; $display("FAIL ins_valid: got %0b expected %0b", ins_valid_out, ev);
      end
      checks++;
      if (ins_pc_out !== epc) begin
        errors++; $display("FAIL ins_pc: got %h expected %h", ins_pc_out, epc);
      end
      checks++;
      if (ins_data_out !== edata) begin
        errors++; $display("FAIL ins_data: got %h expected %h", ins_data_out, edata);
      end
    end
    s_rst = reset_in; s_halt = halt_in; s_flush = flush_in; s_faddr = flush_addr_in;
    s_read = mem_read_out; s_valid = mem_valid_in; s_data = mem_data_in; s_ready = ins_ready_in;
    @(posedge clk);
    #1;
    if (s_rst) begin
      exp_q.delete();
      discard = 1'b0; exp_read = 1'b0; exp_req = RESET_PC; exp_addr = RESET_PC;
      last_pc = '0; last_data = '0; model_ok = 1'b1;
    end else if (model_ok) begin
      resp = s_read && s_valid;
      byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = (exp_q.size() == 0) && resp && !discard && !s_flush;
`endif
      if (s_read) nxt = !s_valid;
      else        nxt = !s_halt && !s_flush && (exp_q.size() < DEPTH);
      if (s_flush) begin
        exp_q.delete();
        exp_req = s_faddr;
        if (s_read) discard = !s_valid;
      end else begin
        if (exp_q.size() > 0 && s_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
        if (resp) begin
          if (discard) begin
            discard = 1'b0;
          end else begin
            exp_req = exp_req + 32'd4;
            if (byp && s_ready) delivered++;
            else exp_q.push_back({exp_addr, s_data});
          end
        end
      end
      if (!s_read && nxt) exp_addr = exp_req;
      exp_read = nxt;
    end
    if (mem_en) begin
      if (mem_valid_in) begin
        mem_valid_in = 1'b0;
        wait_cnt = 0;
      end else if (mem_read_out) begin
        if (wait_cnt >= lat) begin
          mem_valid_in = 1'b1;
          mem_data_in = $urandom;
          wait_cnt = 0;
          if (rand_lat) lat = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  endtask

  // driver tasks
  task automatic do_reset();
    mem_valid_in = 1'b0;
    wait_cnt = 0;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
  endtask

  task automatic wait_for_read(input int max_cycles, input string name);
    int n;
    n = 0;
    while (!mem_read_out && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (!mem_read_out) begin
      errors++; $display("FAIL %s: no request within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1; halt_in = 1'b0; flush_in = 1'b0; flush_addr_in = '0;
    mem_valid_in = 1'b0; mem_data_in = '0; ins_ready_in = 1'b0; mem_en = 1'b0;
    tick();
    tick();
    reset_in = 1'b0;
    checks++; if (mem_read_out !== 1'b0) begin errors++; $display("FAIL reset_read: got %0b expected 0", mem_read_out); end
    checks++; if (mem_addr_out !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", mem_addr_out, RESET_PC); end
    checks++; if (ins_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", ins_valid_out); end
    checks++; if (ins_data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", ins_data_out); end
    checks++; if (ins_pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", ins_pc_out); end
    checks++; if (count_out !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_out); end
  endtask

  task automatic test_sequential();
    int d0;
    d0 = delivered;
    ins_ready_in = 1'b1; lat = 0; rand_lat = 1'b0; wait_cnt = 0; mem_en = 1'b1;
    repeat (30) tick();
    checks++;
    if (delivered - d0 < 8) begin
      errors++; $display("FAIL seq_throughput: got %0d delivered expected at least 8", delivered - d0);
    end
  endtask

  task automatic test_full();
    int n;
    do_reset();
    ins_ready_in = 1'b0; lat = 0; rand_lat = 1'b0; mem_en = 1'b1;
    n = 0;
    while (count_out != CW'(DEPTH) && n < 40) begin tick(); n++; end
    checks++; if (count_out !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d expected %0d", count_out, DEPTH); end
    repeat (4) tick();
    checks++; if (mem_read_out !== 1'b0) begin errors++; $display("FAIL full_no_req: got %0b expected 0", mem_read_out); end
    ins_ready_in = 1'b1;
    tick();
    ins_ready_in = 1'b0;
    checks++; if (count_out !== CW'(DEPTH - 1)) begin errors++; $display("FAIL full_pop_count: got %0d expected %0d", count_out, DEPTH - 1); end
    wait_for_read(5, "full_refill");
    checks++; if (mem_addr_out !== 32'h10) begin errors++; $display("FAIL full_refill_addr: got %h expected 00000010", mem_addr_out); end
    repeat (6) tick();
    checks++; if (count_out !== CW'(DEPTH)) begin errors++; $display("FAIL full_refilled: got %0d expected %0d", count_out, DEPTH); end
    checks++; if (mem_read_out !== 1'b0) begin errors++; $display("FAIL full_one_req: got %0b expected 0", mem_read_out); end
  endtask

  task automatic test_flush_wait();
    logic found;
    int   n;
    mem_en = 1'b0;
    do_reset();
    ins_ready_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (mem_valid_in) mem_valid_in = 1'b0;
      else if (mem_read_out) begin
        if (mem_addr_out == 32'h8) found = 1'b1;
        else begin mem_valid_in = 1'b1; mem_data_in = $urandom; end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL flushw_reach: got no request to 8 expected one"); end
    flush_in = 1'b1; flush_addr_in = 32'h100;
    tick();
    flush_in = 1'b0;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL flushw_count: got %0d expected 0", count_out); end
    checks++; if (mem_read_out !== 1'b1 || mem_addr_out !== 32'h8) begin
      errors++; $display("FAIL flushw_hold: got %0b/%h expected 1/00000008", mem_read_out, mem_addr_out);
    end
    tick();
    tick();
    mem_valid_in = 1'b1; mem_data_in = 32'hDEAD_BEEF;
    tick();
    mem_valid_in = 1'b0;
    checks++; if (count_out !== '0) begin errors++; $display("FAIL flushw_drop: got %0d expected 0", count_out); end
    ins_ready_in = 1'b1; lat = 1; wait_cnt = 0; mem_en = 1'b1;
    wait_for_read(5, "flushw_req");
    checks++; if (mem_addr_out !== 32'h100) begin errors++; $display("FAIL flushw_addr: got %h expected 00000100", mem_addr_out); end
    n = 0;
    while (!ins_valid_out && n < 10) begin tick(); n++; end
    checks++; if (ins_pc_out !== 32'h100 || !ins_valid_out) begin
      errors++; $display("FAIL flushw_pc: got %h expected 00000100", ins_pc_out);
    end
  endtask

  task automatic test_flush_same_cycle();
    logic hit;
    do_reset();
    ins_ready_in = 1'b0; lat = 1; rand_lat = 1'b1; mem_en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (mem_valid_in && count_out == CW'(1)) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL flushs_reach: got no second response expected one"); end
    flush_in = 1'b1; flush_addr_in = 32'h200;
    tick();
    flush_in = 1'b0;
    checks++; if (count_out !== '0 || ins_valid_out !== 1'b0) begin
      errors++; $display("FAIL flushs_nopush: got count %0d valid %0b expected 0/0", count_out, ins_valid_out);
    end
    wait_for_read(5, "flushs_req");
    checks++; if (mem_addr_out !== 32'h200) begin errors++; $display("FAIL flushs_addr: got %h expected 00000200", mem_addr_out); end
    ins_ready_in = 1'b1;
    repeat (10) tick();
    rand_lat = 1'b0;
  endtask

  task automatic test_halt_wrap();
    mem_en = 1'b0;
    do_reset();
    ins_ready_in = 1'b1;
    flush_in = 1'b1; flush_addr_in = 32'hFFFF_FFFC;
    tick();
    flush_in = 1'b0;
    wait_for_read(5, "halt_req");
    checks++; if (mem_addr_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL halt_addr: got %h expected fffffffc", mem_addr_out); end
    halt_in = 1'b1;
    tick();
    tick();
    mem_valid_in = 1'b1; mem_data_in = 32'h1234_5678;
    tick();
    mem_valid_in = 1'b0;
    checks++; if (ins_valid_out !== 1'b1 || ins_pc_out !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL halt_queued: got %0b/%h expected 1/fffffffc", ins_valid_out, ins_pc_out);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (mem_read_out !== 1'b0) begin errors++; $display("FAIL halt_hold: got %0b expected 0", mem_read_out); end
    end
    halt_in = 1'b0;
    wait_for_read(5, "halt_resume");
    checks++; if (mem_addr_out !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", mem_addr_out); end
  endtask

  task automatic test_reset_mid_request();
    mem_en = 1'b0;
    wait_for_read(5, "rstmid_req");
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    checks++; if (mem_read_out !== 1'b0 || count_out !== '0) begin
      errors++; $display("FAIL rstmid: got read %0b count %0d expected 0/0", mem_read_out, count_out);
    end
  endtask

  task automatic test_bypass();
    mem_en = 1'b0;
    do_reset();
    ins_ready_in = 1'b1;
    wait_for_read(5, "byp_req");
    mem_valid_in = 1'b1; mem_data_in = 32'hCAFE_F00D;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    checks++; if (ins_valid_out !== 1'b1 || ins_data_out !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL byp_same: got %0b/%h expected 1/cafef00d", ins_valid_out, ins_data_out);
    end
`else
    checks++; if (ins_valid_out !== 1'b0) begin errors++; $display("FAIL byp_same: got %0b expected 0", ins_valid_out); end
`endif
    tick();
    mem_valid_in = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    checks++; if (count_out !== '0) begin errors++; $display("FAIL byp_count: got %0d expected 0", count_out); end
`else
    checks++; if (ins_valid_out !== 1'b1 || ins_data_out !== 32'hCAFE_F00D || count_out !== CW'(1)) begin
      errors++; $display("FAIL byp_next: got %0b/%h/%0d expected 1/cafef00d/1", ins_valid_out, ins_data_out, count_out);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    do_reset();
    rand_lat = 1'b1; lat = 0; wait_cnt = 0; mem_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ins_ready_in = ($urandom_range(0, 3) != 0);
      halt_in = ($urandom_range(0, 9) == 0);
      flush_in = ($urandom_range(0, 24) == 0);
      flush_addr_in = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      tick();
    end
    flush_in = 1'b0; halt_in = 1'b0; ins_ready_in = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_flush_wait();
    test_flush_same_cycle();
    test_halt_wrap();
    test_reset_mid_request();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between main memory and the decode stage.
- Autonomously issues sequential word fetches over a read/valid memory handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Presents instructions to decode through a valid/ready handshake; supports flush-with-redirect for branches and a halt input.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clock_in  input  1  core clock; all state updates on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- halt_in  input  1  when 1, no new memory request is started.
- flush_in  input  1  discard queue contents and any in-flight response; redirect fetch.
- flush_addr_in  input  32  new fetch PC, sampled when flush_in=1.
- mem_addr_out  output  32  fetch address; stable while mem_read_out=1.
- mem_read_out  output  1  memory read request; held until mem_valid_in.
- mem_valid_in  input  1  response valid; completes the outstanding request.
- mem_data_in  input  32  instruction word, valid with mem_valid_in.
- ins_valid_out  output  1  head entry valid for decode.
- ins_data_out  output  32  head instruction word.
- ins_pc_out  output  32  PC of head instruction.
- ins_ready_in  input  1  decode accepts the head entry this cycle.
- count_out  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset values:
  - mem_read_out=0, mem_addr_out=RESET_PC.
  - ins_valid_out=0, ins_data_out=0, ins_pc_out=0, count_out=0.
  - Internal fetch_pc=RESET_PC; FSM in IDLE.
- At most one outstanding memory request.
- FSM states:
  - IDLE: go to WAIT if halt_in=0, flush_in=0 and count_out<DEPTH. Drive mem_read_out=1 and mem_addr_out=fetch_pc from the next cycle.
  - WAIT: hold mem_read_out=1 and mem_addr_out constant.
    - On mem_valid_in=1: push {fetch_pc, mem_data_in}, set fetch_pc+=4, deassert mem_read_out, return to IDLE.
    - IDLE may reissue on the following cycle, so the minimum request spacing is 2 cycles.
  - DISCARD: entered from WAIT on flush_in=1 without mem_valid_in. Hold mem_read_out=1 with the old address until mem_valid_in, drop that data, then go to IDLE.
- fetch_pc arithmetic: 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
- Pop: when ins_valid_out=1 and ins_ready_in=1, the head advances at the clock edge.
- Push and pop in the same cycle: count unchanged, both take effect.
- Full queue: no request is issued. A response can never arrive when full, because issue requires count_out<DEPTH and count never rises while WAIT is pending.
- Empty queue: ins_valid_out=0; ins_data_out and ins_pc_out hold their last values.
- Flush (flush_in=1), effective next cycle:
  - count_out=0, ins_valid_out=0, fetch_pc=flush_addr_in.
  - Any pop or push that cycle is cancelled.
  - If in WAIT with mem_valid_in=1 in the same cycle: the response is dropped and the FSM goes to IDLE.
  - If in WAIT without mem_valid_in: go to DISCARD.
  - Flush in IDLE or DISCARD: only the PC and queue update; DISCARD continues.
  - The first post-flush request uses flush_addr_in.
- Halt:
  - A request already in WAIT completes normally.
  - Pops continue.
  - Flush still works while halted.
- A reset asserted mid-request abandons the request; the memory side sees mem_read_out=0 next cycle.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count_out=0, FSM is in WAIT, mem_valid_in=1 and flush_in=0, the response is forwarded combinationally the same cycle: ins_valid_out=1, ins_data_out=mem_data_in, ins_pc_out=fetch_pc.
  - If ins_ready_in=1 it is consumed and not stored; otherwise it is pushed normally.
- Undefined: a response is visible on ins_valid_out no earlier than the cycle after mem_valid_in. All outputs except the mem_* signals are then register-driven.

Test Plan:
- Reset, then memory always responds 1 cycle after request, ins_ready_in=1 → mem_addr_out sequence 0x0,0x4,0x8,…; ins_pc_out matches; data returned in order.
- ins_ready_in=0, DEPTH=4 → after 4 responses count_out=4, mem_read_out stays 0; raise ready for 1 cycle → count_out=3, exactly one new request to 0x10.
- In WAIT at addr 0x8, flush_in=1 with flush_addr_in=0x100, response arrives 3 cycles later → response dropped, count_out=0, next request to 0x100, first ins_pc_out=0x100.
- flush_in and mem_valid_in in the same cycle → no entry pushed, next request addr=flush_addr_in.
- halt_in=1 while in WAIT → that response is queued, no further mem_read_out until halt_in=0; fetch_pc=0xFFFFFFFC → following request addr 0x0.
- With FETCH_QUEUE_BYPASS_EN, empty queue, ready=1 → ins_valid_out=1 in the same cycle as mem_valid_in, count_out stays 0; without the macro → valid one cycle later.
